// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability-count debouncer and a
// press-tracking FSM producing a clean level plus press/release/long pulses.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 100000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int unsigned STAB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    logic              r_ff1;
    logic              r_ff2;
    logic [STAB_W-1:0] r_stab;
    logic              r_level;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_press;
    logic              r_release;
    logic              r_long;
    logic              w_press_nxt;
    logic              w_release_nxt;
    logic              w_long_nxt;

    logic w_s;
    logic w_differs;
    logic w_commit;
    logic w_rise;
    logic w_fall;
    logic w_hold_done;

    assign w_s         = r_ff2;
    assign w_differs   = (w_s != r_level);
    assign w_commit    = w_differs && (r_stab == STAB_LAST);
    assign w_rise      = w_commit && w_s;
    assign w_fall      = w_commit && !w_s;
    assign w_hold_done = (r_hold == HOLD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ff1 <= 1'b0;
            r_ff2 <= 1'b0;
        end else begin
            r_ff1 <= btn_in;
            r_ff2 <= r_ff1;
        end
    end

    // Any sample back at the committed level is a bounce and restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stab  <= '0;
            r_level <= 1'b0;
        end else if (!w_differs) begin
            r_stab <= '0;
        end else if (w_commit) begin
            r_stab  <= '0;
            r_level <= w_s;
        end else begin
            r_stab <= r_stab + STAB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_hold    <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_long    <= w_long_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        unique case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = PRESSED;
                    w_hold_nxt  = '0;
                end
            end
            PRESSED: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    w_hold_nxt  = '0;
                end else if (w_hold_done) begin
                    w_state_nxt = HELD;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            HELD: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    w_hold_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Pulse values are decoded here and registered so they align with btn_level.
    always_comb begin
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        unique case (r_state)
            IDLE:    w_press_nxt = w_rise;
            PRESSED: begin
                w_release_nxt = w_fall;
                w_long_nxt    = !w_fall && w_hold_done;
            end
            HELD:    w_release_nxt = w_fall;
            default: ;
        endcase
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign btn_long    = r_long;

endmodule
